cf_ctrl_status: RTL and testbench

Status/control register block for the CompactFlash interface. It sits directly downstream of the CF bus-cycle controller's n_rdstat/n_wrcon strobes and feeds that controller's t[1:0] PIO timing mode. It also owns the card-side housekeeping:
- card-detect debounce
- card reset pulse sequencing
- card power enable
- CPU interrupt generation from card INTRQ and card-change events.

---
 rtl/cf_pkg.sv | 38 +++
 rtl/cf_ctrl_status_if.sv | 14 +
 rtl/cf_sync_debounce.sv | 64 ++++++
 rtl/cf_ctrl_status.sv | 177 +++++++++++++++++
 tb/tb_cf_ctrl_status.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cf_pkg.sv
// Shared constants and payload types for the CompactFlash status/control block.
// PIO mode encodings are also consumed by the CF bus-cycle controller.
package cf_pkg;

  localparam int unsigned CTRL_W = 8;

  localparam logic [1:0] MODE_PIO01 = 2'b00;
  localparam logic [1:0] MODE_PIO23 = 2'b01;
  localparam logic [1:0] MODE_PIO4  = 2'b10;
  localparam logic [1:0] MODE_ASYNC = 2'b11;

  // Card reset sequencer states
  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_ASSERT = 2'd1;
  localparam logic [1:0] R_WAIT   = 2'd2;

  // Control byte written on D15..D8, MSB first
  typedef struct packed {
    logic [1:0] rsvd;
    logic       clr_chg;
    logic       pwr_en;
    logic       ie;
    logic       rst_req;
    logic [1:0] mode;
  } cf_ctrl_t;

  // Status byte returned on reads, MSB first
  typedef struct packed {
    logic       intrq;
    logic       present;
    logic       chg;
    logic       pwr_en;
    logic       ie;
    logic       busy;
    logic [1:0] mode;
  } cf_status_t;

endpackage

// File: rtl/cf_ctrl_status_if.sv
// CPU-side strobe/data bus of the CF status/control register.
interface cf_ctrl_status_if;
  import cf_pkg::*;

  logic              n_rdstat;
  logic              n_wrcon;
  logic [CTRL_W-1:0] d_in;
  logic [CTRL_W-1:0] d_out;
  logic              d_oe;

  modport master (output n_rdstat, n_wrcon, d_in, input d_out, d_oe);
  modport slave  (input n_rdstat, n_wrcon, d_in, output d_out, d_oe);

endinterface

// File: rtl/cf_sync_debounce.sv
// Card-detect synchroniser and debouncer: present follows !n_cd once the input
// has been stable for 2^DB_BITS clocks; change_c pulses on the updating clock.
module cf_sync_debounce #(
  parameter int unsigned DB_BITS = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic n_cd,
  output logic present,
  output logic change_c
);

  logic               cd_meta_q, cd_meta_d;
  logic               cd_sync_q, cd_sync_d;
  logic               cd_prev_q, cd_prev_d;
  logic               present_q, present_d;
  logic [DB_BITS-1:0] cnt_q, cnt_d;
  logic               cd_now_c;

  assign cd_now_c = !cd_sync_q;

  // Counter restarts on any sample-to-sample change and only runs while the
  // settled input disagrees with the reported state.
  always_comb begin
    cd_meta_d = n_cd;
    cd_sync_d = cd_meta_q;
    cd_prev_d = cd_now_c;
    present_d = present_q;
    cnt_d     = cnt_q;
    change_c  = 1'b0;
    if (cd_now_c != cd_prev_q) begin
      cnt_d = '0;
    end else if (cd_now_c != present_q) begin
      if (cnt_q == '1) begin
        present_d = cd_now_c;
        cnt_d     = '0;
        change_c  = 1'b1;
      end else begin
        cnt_d = cnt_q + DB_BITS'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_meta_q <= 1'b1;
      cd_sync_q <= 1'b1;
      cd_prev_q <= 1'b0;
      present_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cd_meta_q <= cd_meta_d;
      cd_sync_q <= cd_sync_d;
      cd_prev_q <= cd_prev_d;
      present_q <= present_d;
      cnt_q     <= cnt_d;
    end
  end

  assign present = present_q;

endmodule

// File: rtl/cf_ctrl_status.sv
// CompactFlash status/control register: PIO mode, card power, reset
// sequencing, card-detect debounce and CPU interrupt generation.
module cf_ctrl_status
  import cf_pkg::*;
#(
  parameter int unsigned DB_BITS         = 19,
  parameter int unsigned RST_CYCLES      = 1024,
  parameter int unsigned RST_WAIT_CYCLES = 80,
  parameter int unsigned RST_CNT_BITS    = 11
) (
  input  logic                   osc_40mhz,
  input  logic                   n_reset,
  cf_ctrl_status_if.slave        bus,
  output logic [1:0]             t,
  input  logic                   n_cd,
  input  logic                   cf_intrq,
  output logic                   n_cf_reset,
  output logic                   cf_pwr_en,
  output logic                   n_irq
);

  logic                    wr_meta_q, wr_meta_d;
  logic                    wr_sync_q, wr_sync_d;
  logic                    wr_prev_q, wr_prev_d;
  logic                    intrq_meta_q, intrq_meta_d;
  logic                    intrq_sync_q, intrq_sync_d;
  logic [1:0]              t_q, t_d;
  logic                    ie_q, ie_d;
  logic                    pwr_q, pwr_d;
  logic                    pwr_prev_q, pwr_prev_d;
  logic                    pres_prev_q, pres_prev_d;
  logic                    chg_q, chg_d;
  logic [1:0]              state_q, state_d;
  logic [RST_CNT_BITS-1:0] cnt_q, cnt_d;
  logic                    n_cf_reset_q, n_cf_reset_d;
  logic                    n_irq_q, n_irq_d;

  logic       present;
  logic       change_c;
  logic       wr_pulse_c;
  logic       rst_req_c;
  logic       busy_c;
  cf_ctrl_t   ctrl_c;
  cf_status_t status_c;

  cf_sync_debounce #(.DB_BITS(DB_BITS)) u_cd (
    .clk      (osc_40mhz),
    .rst_n    (n_reset),
    .n_cd     (n_cd),
    .present  (present),
    .change_c (change_c)
  );

  assign ctrl_c     = cf_ctrl_t'(bus.d_in);
  assign wr_pulse_c = !wr_sync_q && wr_prev_q;
  assign rst_req_c  = wr_pulse_c && ctrl_c.rst_req;
  assign busy_c     = (state_q != R_IDLE);

  // Strobe/INTRQ synchronisers and control register
  always_comb begin
    wr_meta_d    = bus.n_wrcon;
    wr_sync_d    = wr_meta_q;
    wr_prev_d    = wr_sync_q;
    intrq_meta_d = cf_intrq;
    intrq_sync_d = intrq_meta_q;
    pwr_prev_d   = pwr_q;
    pres_prev_d  = present;
    t_d          = t_q;
    ie_d         = ie_q;
    pwr_d        = pwr_q;
    chg_d        = chg_q;
    if (wr_pulse_c) begin
      t_d   = ctrl_c.mode;
      ie_d  = ctrl_c.ie;
      pwr_d = ctrl_c.pwr_en;
      if (ctrl_c.clr_chg) chg_d = 1'b0;
    end
    if (change_c) chg_d = 1'b1;
  end

  // Card reset sequencer; held at the start of R_ASSERT while unpowered or absent
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!pwr_q || !present) begin
      state_d = R_ASSERT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (rst_req_c || (present && !pres_prev_q) || (pwr_q && !pwr_prev_q)) begin
            state_d = R_ASSERT;
            cnt_d   = '0;
          end
        end
        R_ASSERT: begin
          if (cnt_q == RST_CNT_BITS'(RST_CYCLES - 1)) begin
            state_d = R_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + RST_CNT_BITS'(1);
          end
        end
        R_WAIT: begin
          if (cnt_q == RST_CNT_BITS'(RST_WAIT_CYCLES - 1)) begin
            state_d = R_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + RST_CNT_BITS'(1);
          end
        end
        default: begin
          state_d = R_ASSERT;
          cnt_d   = '0;
        end
      endcase
    end
    n_cf_reset_d = (state_d != R_ASSERT);
    n_irq_d      = !(ie_q && ((intrq_sync_q && !busy_c) || chg_q));
  end

  always_ff @(posedge osc_40mhz or negedge n_reset) begin
    if (!n_reset) begin
      wr_meta_q    <= 1'b1;
      wr_sync_q    <= 1'b1;
      wr_prev_q    <= 1'b1;
      intrq_meta_q <= 1'b0;
      intrq_sync_q <= 1'b0;
      t_q          <= MODE_PIO01;
      ie_q         <= 1'b0;
      pwr_q        <= 1'b0;
      pwr_prev_q   <= 1'b0;
      pres_prev_q  <= 1'b0;
      chg_q        <= 1'b0;
      state_q      <= R_ASSERT;
      cnt_q        <= '0;
      n_cf_reset_q <= 1'b0;
      n_irq_q      <= 1'b1;
    end else begin
      wr_meta_q    <= wr_meta_d;
      wr_sync_q    <= wr_sync_d;
      wr_prev_q    <= wr_prev_d;
      intrq_meta_q <= intrq_meta_d;
      intrq_sync_q <= intrq_sync_d;
      t_q          <= t_d;
      ie_q         <= ie_d;
      pwr_q        <= pwr_d;
      pwr_prev_q   <= pwr_prev_d;
      pres_prev_q  <= pres_prev_d;
      chg_q        <= chg_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_cf_reset_q <= n_cf_reset_d;
      n_irq_q      <= n_irq_d;
    end
  end

  always_comb begin
    status_c         = '0;
    status_c.intrq   = intrq_sync_q;
    status_c.present = present;
    status_c.chg     = chg_q;
    status_c.pwr_en  = pwr_q;
    status_c.ie      = ie_q;
    status_c.busy    = busy_c;
    status_c.mode    = t_q;
  end

  // Output enable bypasses the synchronisers so DTACK is not delayed
  assign bus.d_out  = status_c;
  assign bus.d_oe   = !bus.n_rdstat;
  assign t          = t_q;
  assign cf_pwr_en  = pwr_q;
  assign n_cf_reset = n_cf_reset_q;
  assign n_irq      = n_irq_q;

endmodule

// File: tb/tb_cf_ctrl_status.sv
// Bench for cf_ctrl_status with shortened debounce and reset timings.
module tb_cf_ctrl_status;
  import cf_pkg::*;

  localparam int unsigned DB = 4;
  localparam int unsigned RC = 16;
  localparam int unsigned RW = 8;
  localparam int unsigned CB = 5;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [1:0] t;
  logic       n_cd, cf_intrq, n_cf_reset, cf_pwr_en, n_irq;

  cf_ctrl_status_if bus();

  cf_ctrl_status #(
    .DB_BITS(DB), .RST_CYCLES(RC), .RST_WAIT_CYCLES(RW), .RST_CNT_BITS(CB)
  ) dut (
    .osc_40mhz  (clk),
    .n_reset    (n_reset),
    .bus        (bus),
    .t          (t),
    .n_cd       (n_cd),
    .cf_intrq   (cf_intrq),
    .n_cf_reset (n_cf_reset),
    .cf_pwr_en  (cf_pwr_en),
    .n_irq      (n_irq)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic [7:0] din;
    logic       intrq;
    logic [7:0] status;
    logic       nirq;
  } vec_t;
  vec_t vecs[8];

  // Records the length of each n_cf_reset low run and each post-release busy run
  int low_cnt = 0, wt_cnt = 0, low_run = 0, wait_run = 0, n_runs = 0;
  always @(negedge clk) begin
    if (!n_reset) begin
      low_cnt = 0;
      wt_cnt  = 0;
    end else if (!n_cf_reset) begin
      low_cnt = low_cnt + 1;
    end else begin
      if (low_cnt != 0) begin
        low_run = low_cnt;
        n_runs  = n_runs + 1;
        low_cnt = 0;
      end
      if (bus.d_out[2]) wt_cnt = wt_cnt + 1;
      else if (wt_cnt != 0) begin
        wait_run = wt_cnt;
        wt_cnt   = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    bus.d_in    = d;
    bus.n_wrcon = 1'b0;
    cyc(3);
    bus.n_wrcon = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [7:0] exp);
    bus.n_rdstat = 1'b0;
    #1;
    check({name, "_oe"}, int'(bus.d_oe), 1);
    check(name, int'(bus.d_out), int'(exp));
    bus.n_rdstat = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.d_out[2] && n < budget) begin
      cyc(1);
      n++;
    end
    check("idle_reached", int'(bus.d_out[2]), 0);
  endtask

  initial begin
    int k, low, wt, n, runs0, changes;
    logic ok, p;
    logic [7:0] e;

    vecs[0] = '{din: 8'h10, intrq: 1'b0, status: 8'h50, nirq: 1'b1};
    vecs[1] = '{din: 8'h12, intrq: 1'b0, status: 8'h52, nirq: 1'b1};
    vecs[2] = '{din: 8'hD3, intrq: 1'b0, status: 8'h53, nirq: 1'b1};
    vecs[3] = '{din: 8'h1A, intrq: 1'b0, status: 8'h5A, nirq: 1'b1};
    vecs[4] = '{din: 8'h19, intrq: 1'b1, status: 8'hD9, nirq: 1'b0};
    vecs[5] = '{din: 8'h11, intrq: 1'b1, status: 8'hD1, nirq: 1'b1};
    vecs[6] = '{din: 8'h3B, intrq: 1'b0, status: 8'h5B, nirq: 1'b1};
    vecs[7] = '{din: 8'h10, intrq: 1'b0, status: 8'h50, nirq: 1'b1};

    n_reset = 1'b0; n_cd = 1'b1; cf_intrq = 1'b0;
    bus.n_wrcon = 1'b1; bus.n_rdstat = 1'b1; bus.d_in = 8'h00;
    cyc(2);
    check("rst_t", int'(t), 0);
    check("rst_nirq", int'(n_irq), 1);
    check("rst_ncfreset", int'(n_cf_reset), 0);
    check("rst_pwr", int'(cf_pwr_en), 0);
    check("rst_status", int'(bus.d_out), 8'h04);
    check("rst_doe", int'(bus.d_oe), 0);
    n_reset = 1'b1;
    cyc(3);

    // Power on with no card, then insert it
    wr(8'h10);
    check("pwr_on", int'(cf_pwr_en), 1);
    ok = 1'b1;
    repeat (20) begin
      cyc(1);
      if (n_cf_reset !== 1'b0) ok = 1'b0;
    end
    check("held_no_card", int'(ok), 1);
    n_cd = 1'b0;
    k = 0;
    while (!bus.d_out[6] && k < 30) begin
      cyc(1);
      k++;
    end
    check_rng("present_latency", k, 18, 19);
    low = 0; wt = 0; n = 0;
    while (n < 60) begin
      if (!n_cf_reset) low++;
      else if (bus.d_out[2]) wt++;
      else break;
      cyc(1);
      n++;
    end
    check("ins_low_len", low, 16);
    check("ins_wait_len", wt, 8);
    rd_check("ins_status", 8'h70);
    check("ins_nirq", int'(n_irq), 1);

    // PIO mode latency and chg interrupt
    bus.d_in = 8'h19; bus.n_wrcon = 1'b0;
    cyc(2);
    check("t_before_3clk", int'(t), 0);
    cyc(1);
    check("t_at_3clk", int'(t), 1);
    bus.n_wrcon = 1'b1;
    cyc(1);
    check("irq_chg", int'(n_irq), 0);
    cyc(2);
    wr(8'h39);
    check("chg_cleared", int'(bus.d_out[5]), 0);
    cyc(1);
    check("irq_after_clr", int'(n_irq), 1);
    cyc(2);

    // Control write table through the scoreboard
    for (int i = 0; i < 8; i++) begin
      cf_intrq    = vecs[i].intrq;
      bus.d_in    = vecs[i].din;
      bus.n_wrcon = 1'b0;
      exp_q.push_back(vecs[i].status);
      cyc(3);
      bus.n_wrcon = 1'b1;
      e = exp_q.pop_front();
      rd_check($sformatf("vec%0d_status", i), e);
      cyc(1);
      check($sformatf("vec%0d_nirq", i), int'(n_irq), int'(vecs[i].nirq));
      cyc(2);
    end

    // Reset request, second request mid-sequence is ignored
    runs0 = n_runs;
    wr(8'h14);
    check("req_ncfreset", int'(n_cf_reset), 0);
    cyc(3);
    wr(8'h14);
    wait_idle(60);
    cyc(1);
    check("req_runs", n_runs, runs0 + 1);
    check("req_low_len", low_run, 16);
    check("req_wait_len", wait_run, 8);

    // INTRQ masked while busy, then asserted once idle
    wr(8'h1C);
    cyc(1);
    cf_intrq = 1'b1;
    cyc(4);
    check("irq_masked_busy", int'(n_irq), 1);
    wait_idle(60);
    k = 0;
    while (n_irq && k < 5) begin
      cyc(1);
      k++;
    end
    check_rng("irq_after_idle", k, 1, 3);
    cf_intrq = 1'b0;
    cyc(3);

    // Long strobe executes once
    runs0 = n_runs;
    bus.d_in = 8'h14; bus.n_wrcon = 1'b0;
    cyc(20);
    bus.d_in = 8'h17;
    cyc(20);
    bus.n_wrcon = 1'b1;
    cyc(3);
    check("hold_t", int'(t), 0);
    check("hold_busy", int'(bus.d_out[2]), 0);
    check("hold_runs", n_runs, runs0 + 1);

    // Bouncing card detect, then removal
    wr(8'h30);
    check("bounce_chg0", int'(bus.d_out[5]), 0);
    ok = 1'b1;
    for (int i = 0; i < 19; i++) begin
      n_cd = ~n_cd;
      repeat (5) begin
        cyc(1);
        if (bus.d_out[6] !== 1'b1) ok = 1'b0;
      end
    end
    check("bounce_stable", int'(ok), 1);
    check("bounce_no_chg", int'(bus.d_out[5]), 0);
    k = 5;
    while (bus.d_out[6] && k < 40) begin
      cyc(1);
      k++;
    end
    check_rng("settle_latency", k, 18, 19);
    check("settle_chg", int'(bus.d_out[5]), 1);
    changes = 0;
    repeat (10) begin
      p = bus.d_out[6];
      cyc(1);
      if (bus.d_out[6] != p) changes++;
    end
    check("settle_once", changes, 0);

    // chg set and write-1-to-clear on the same clock
    wr(8'h30);
    check("pre_chg0", int'(bus.d_out[5]), 0);
    n_cd = 1'b0;
    cyc(16);
    bus.d_in = 8'h3B; bus.n_wrcon = 1'b0;
    cyc(2);
    check("pre_present", int'(bus.d_out[6]), 0);
    cyc(1);
    check("same_clk_present", int'(bus.d_out[6]), 1);
    check("same_clk_chg", int'(bus.d_out[5]), 1);
    bus.n_wrcon = 1'b1;
    cyc(1);
    check("same_clk_nirq", int'(n_irq), 0);
    check("same_clk_t", int'(t), 3);

    // Asynchronous reset during R_WAIT
    k = 0;
    while (!(n_cf_reset && bus.d_out[2]) && k < 60) begin
      cyc(1);
      k++;
    end
    check("reached_wait", int'(n_cf_reset && bus.d_out[2]), 1);
    cyc(3);
    #2;
    n_reset = 1'b0;
    #1;
    check("async_ncfreset", int'(n_cf_reset), 0);
    check("async_pwr", int'(cf_pwr_en), 0);
    check("async_t", int'(t), 0);
    check("async_nirq", int'(n_irq), 1);
    check("async_status", int'(bus.d_out), 8'h04);
    cyc(2);
    n_reset = 1'b1;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
